// File: rtl/req_pending_pkg.sv
// Shared types and helpers for the request-pending arbiter.
// Provides default sizes, the handshake FSM state type and a priority encoder.
package req_pending_pkg;

    localparam int NCH_DEF   = 4;
    localparam int IDX_W_DEF = 2;

    typedef enum logic {
        ST_IDLE,
        ST_PRESENT
    } st_t;

    // Highest set bit index of a vector of up to 16 channels, 0 if none.
    function automatic logic [3:0] hi_index(input logic [15:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/req_edge_detect.sv
// Rising-edge detector for NCH request lines (registered req_q, comb rise_o).
// Ports: clk, rst (sync, active-high), req_i[NCH], rise_o[NCH].
module req_edge_detect
    import req_pending_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req_i,
    output logic [NCH-1:0] rise_o
);

    logic [NCH-1:0] req_q;

    // req_q clears in reset, so a line held high through reset
    // produces exactly one edge on the first post-reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else begin
            req_q <= req_i;
        end
    end

    assign rise_o = req_i & ~req_q;

endmodule

// File: rtl/req_pending_arbiter.sv
// Sticky pending-bit arbiter: latches request edges, grants highest index
// on a valid/ready handshake and clears the pending bit on accept.
// Ports: clk, rst (sync, active-high), req[NCH], out_ready,
//        out_valid, out_idx[IDX_W], pending[NCH], drop.
// Optional: define REQ_PENDING_MASK_EN to add input mask[NCH] that keeps
//           channels from being granted while still latching them.
module req_pending_arbiter
    import req_pending_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
`ifdef REQ_PENDING_MASK_EN
    input  logic [NCH-1:0]   mask,
`endif
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [NCH-1:0]   pending,
    output logic             drop
);

    st_t              state_q, state_d;
    logic [NCH-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             drop_q, drop_d;

    logic [NCH-1:0]   rise;
    logic [NCH-1:0]   clr;
    logic [NCH-1:0]   eligible;
    logic [15:0]      elig_ext;
    logic             accept;

    req_edge_detect #(
        .NCH    (NCH)
    ) u_edge (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req),
        .rise_o (rise)
    );

`ifdef REQ_PENDING_MASK_EN
    assign eligible = pending_q & ~mask;
`else
    assign eligible = pending_q;
`endif

    assign accept = (state_q == ST_PRESENT) & out_ready;

    always_comb begin
        clr = '0;
        for (int i = 0; i < NCH; i++) begin
            clr[i] = accept & (idx_q == IDX_W'(i));
        end
    end

    always_comb begin
        elig_ext = '0;
        elig_ext[NCH-1:0] = eligible;
    end

    // A new edge wins over the clear, so a channel re-requested on its
    // own accept cycle stays pending and is granted again.
    assign pending_d = (pending_q & ~clr) | rise;
    assign drop_d    = |(rise & pending_q & ~clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d = ST_PRESENT;
                    idx_d   = IDX_W'(hi_index(elig_ext));
                end
            end
            ST_PRESENT: begin
                // Index stays frozen; later edges never pre-empt it.
                if (out_ready) state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_PRESENT);
        out_idx   = idx_q;
        pending   = pending_q;
        drop      = drop_q;
    end

endmodule

// File: tb/tb_req_pending_arbiter.sv
// Randomized scoreboard bench for req_pending_arbiter.
// Grants predicted by a behavioural model are queued and checked on accept.
module tb_req_pending_arbiter;

    localparam int NCH   = 4;
    localparam int IDX_W = 2;
    localparam int NCYC  = 3000;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   mk;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic [NCH-1:0]   pending;
    logic             drop;

    always #5 clk = ~clk;

    req_pending_arbiter #(
        .NCH       (NCH),
        .IDX_W     (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef REQ_PENDING_MASK_EN
        .mask      (mk),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .pending   (pending),
        .drop      (drop)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_grants = 0;
    int exp_q[$];

    // Reference model: channel-level view of the arbiter.
    bit m_prev[NCH];
    bit m_pend[NCH];
    int m_pres;
    bit m_drop;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_step(input bit r, input logic [NCH-1:0] rq,
                              input bit rdy, input logic [NCH-1:0] msk);
        bit accepted;
        bit rise;
        bit nd;
        bit np[NCH];
        int nx;
        if (r) begin
            for (int i = 0; i < NCH; i++) begin
                m_prev[i] = 0;
                m_pend[i] = 0;
            end
            m_pres = -1;
            m_drop = 0;
            return;
        end
        accepted = (m_pres >= 0) && rdy;
        nd = 0;
        for (int i = 0; i < NCH; i++) begin
            rise  = rq[i] && !m_prev[i];
            np[i] = (m_pend[i] && !(accepted && m_pres == i)) || rise;
            if (rise && m_pend[i] && !(accepted && m_pres == i)) nd = 1;
        end
        if (m_pres >= 0) begin
            nx = accepted ? -1 : m_pres;
        end else begin
            nx = -1;
            for (int i = 0; i < NCH; i++)
                if (m_pend[i] && !msk[i]) nx = i;
            if (nx >= 0) exp_q.push_back(nx);
        end
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = np[i];
            m_prev[i] = rq[i];
        end
        m_pres = nx;
        m_drop = nd;
    endtask

    task automatic cycle_and_check();
        model_step(rst, req, out_ready, mk);
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(m_pres >= 0));
        if (m_pres >= 0) check("out_idx", 32'(out_idx), 32'(m_pres));
        check("pending", 32'(pending), pend_vec());
        check("drop", 32'(drop), 32'(m_drop));
    endtask

    // Monitor: every accepted handshake must match the next queued grant.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL grant_idx: got %0d expected none", out_idx);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_idx", 32'(out_idx), 32'(e));
                    n_grants++;
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req       = '1;
        out_ready = 1'b0;
        mk        = '0;
        for (int c = 0; c < 3; c++) cycle_and_check();
        check("rst_out_idx", 32'(out_idx), 32'd0);

        // Lines held high through reset create one edge each.
        rst = 1'b0;
        cycle_and_check();
        check("post_rst_pending", 32'(pending), 32'hF);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        cycle_and_check();
        check("first_grant_valid", 32'(out_valid), 32'd1);
        check("first_grant_idx", 32'(out_idx), 32'd3);

        for (int c = 0; c < NCYC; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            if ((c / 64) % 3 == 2) out_ready = ($urandom_range(0, 7) == 0);
            else out_ready = ($urandom_range(0, 2) != 0);
`ifdef REQ_PENDING_MASK_EN
            if ($urandom_range(0, 15) == 0) mk = NCH'($urandom);
`endif
            if (rst) exp_q.delete();
            cycle_and_check();
        end

        rst       = 1'b0;
        req       = '0;
        out_ready = 1'b1;
        mk        = '0;
        for (int c = 0; c < 20; c++) cycle_and_check();
        @(negedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        n_checks++;
        if (n_grants > 20) n_pass++;
        else $display("FAIL grant_count: got %0d expected >20", n_grants);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
